// File: rtl/pipeline_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid buffer. Latency 1 cycle, and o_ready is registered (it depends on state only).
// Backpressure: it holds up to two entries, then deasserts o_ready. Optional perf counters are enabled by PIPE_STAGE_PERF_EN.
module pipeline_stage_skid #(
  parameter int DATA_WIDTH = 64
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int CNT_WIDTH  = 32
`endif
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]  o_stall_cycles,
  output logic [CNT_WIDTH-1:0]  o_flush_drops
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  accept;
  logic                  deliver;

  assign accept  = i_valid & o_ready;
  assign deliver = o_valid & i_ready;
  assign o_data  = main_q;

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Empty registers are forced to zero so that a bubble always reads as a NOP payload.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (i_flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = i_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (deliver && accept) begin
            main_d = i_data;
          end else if (deliver) begin
            main_d  = '0;
            state_d = EMPTY;
          end else if (accept) begin
            skid_d  = i_data;
            state_d = FULL;
          end
        end
        FULL: begin
          if (deliver) begin
            main_d  = skid_q;
            skid_d  = '0;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    o_valid     = (state_q != EMPTY);
    o_ready     = (state_q != FULL);
    o_occupancy = state_q;
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic [CNT_WIDTH-1:0] drops_q, drops_d;
  logic [CNT_WIDTH:0]   drops_sum;
  logic [1:0]           drop_n;

  // An entry delivered in the flush cycle reached downstream, so it is not counted as dropped.
  always_comb begin
    stall_d = stall_q;
    if (o_valid && !i_ready && (stall_q != '1)) begin
      stall_d = stall_q + CNT_WIDTH'(1);
    end
    drop_n    = o_occupancy - {1'b0, deliver};
    drops_sum = {1'b0, drops_q} + {{(CNT_WIDTH-1){1'b0}}, drop_n};
    drops_d   = drops_q;
    if (i_flush) begin
      drops_d = drops_sum[CNT_WIDTH] ? '1 : drops_sum[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      stall_q <= '0;
      drops_q <= '0;
    end else begin
      stall_q <= stall_d;
      drops_q <= drops_d;
    end
  end

  assign o_stall_cycles = stall_q;
  assign o_flush_drops  = drops_q;
`endif

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Bench for pipeline_stage_skid: directed scenarios pinned with literals, then random traffic
// checked every cycle against a queue model (with narrow saturating counters when PIPE_STAGE_PERF_EN is set).
module tb_pipeline_stage_skid;
  localparam int DW = 64;
  localparam int CW = 4;

  logic          i_clk = 1'b0;
  logic          i_arst, i_flush, i_valid, i_ready;
  logic [DW-1:0] i_data;
  logic          o_ready, o_valid;
  logic [DW-1:0] o_data;
  logic [1:0]    o_occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] o_stall_cycles, o_flush_drops;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

`ifdef PIPE_STAGE_PERF_EN
  pipeline_stage_skid #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .i_clk(i_clk), .i_arst(i_arst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_occupancy(o_occupancy), .o_stall_cycles(o_stall_cycles), .o_flush_drops(o_flush_drops));
`else
  pipeline_stage_skid #(.DATA_WIDTH(DW)) dut (
    .i_clk(i_clk), .i_arst(i_arst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_occupancy(o_occupancy));
`endif

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Reference model: the stage is a FIFO of depth two, and its counters saturate at 2**CW-1.
  logic [DW-1:0] mq[$];
  bit            live = 0;
  int            m_stall = 0;
  int            m_drops = 0;
  localparam int SAT = (1 << CW) - 1;

  always @(posedge i_clk) begin
    if (i_arst) begin
      mq.delete();
      m_stall = 0;
      m_drops = 0;
      live    = 1;
    end else if (live) begin
      bit acc, del;
      acc = i_valid && (mq.size() < 2);
      del = (mq.size() > 0) && i_ready;
      if (mq.size() > 0 && !i_ready) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
      if (i_flush) begin
        m_drops = m_drops + mq.size() - int'(del);
        if (m_drops > SAT) m_drops = SAT;
        mq.delete();
      end else begin
        if (del) void'(mq.pop_front());
        if (acc) mq.push_back(i_data);
      end
    end
  end

  always @(negedge i_clk) begin
    if (live) begin
      chk("valid", {63'd0, o_valid}, {63'd0, mq.size() > 0});
      chk("ready", {63'd0, o_ready}, {63'd0, mq.size() < 2});
      chk("occupancy", {62'd0, o_occupancy}, DW'(mq.size()));
      chk("data", o_data, (mq.size() > 0) ? mq[0] : '0);
`ifdef PIPE_STAGE_PERF_EN
      chk("stall_cycles", DW'(o_stall_cycles), DW'(m_stall));
      chk("flush_drops", DW'(o_flush_drops), DW'(m_drops));
`endif
    end
  end

  initial begin
    i_arst = 1; i_flush = 0; i_valid = 0; i_ready = 0; i_data = '0;
    tick(); tick();
    i_arst = 0;
    chk("rst_valid", {63'd0, o_valid}, 64'd0);
    chk("rst_ready", {63'd0, o_ready}, 64'd1);
    chk("rst_data", o_data, 64'd0);
    chk("rst_occ", {62'd0, o_occupancy}, 64'd0);

    // Streaming: each accepted value appears on o_data in the following cycle.
    i_ready = 1;
    for (int v = 1; v <= 8; v++) begin
      i_valid = 1; i_data = DW'(v);
      tick();
      chk("stream_data", o_data, DW'(v));
      chk("stream_ready", {63'd0, o_ready}, 64'd1);
    end
    i_valid = 0; i_data = '0;
    tick();
    chk("stream_end_valid", {63'd0, o_valid}, 64'd0);
    chk("stream_end_data", o_data, 64'd0);

    // Back-pressure: the skid register absorbs 0xB while 0xA is held.
    i_valid = 1; i_data = 64'hA;
    tick();
    i_ready = 0; i_data = 64'hB;
    tick();
    chk("bp_ready", {63'd0, o_ready}, 64'd0);
    chk("bp_data", o_data, 64'hA);
    chk("bp_occ", {62'd0, o_occupancy}, 64'd2);
    i_data = 64'hEE;
    tick();
    chk("bp_hold_data", o_data, 64'hA);
    i_valid = 0; i_ready = 1;
    tick();
    chk("bp_second", o_data, 64'hB);
    tick();
    chk("bp_drain", {63'd0, o_valid}, 64'd0);

    // A flush in FULL drops both entries and the input offered in the same cycle.
    i_ready = 0; i_valid = 1; i_data = 64'h1;
    tick();
    i_data = 64'h2;
    tick();
    i_flush = 1; i_data = 64'hC;
    tick();
    i_flush = 0; i_valid = 0; i_ready = 1;
    chk("fl_valid", {63'd0, o_valid}, 64'd0);
    chk("fl_data", o_data, 64'd0);
    chk("fl_occ", {62'd0, o_occupancy}, 64'd0);
    chk("fl_ready", {63'd0, o_ready}, 64'd1);
`ifdef PIPE_STAGE_PERF_EN
    chk("fl_drops", DW'(o_flush_drops), 64'd2);
`endif
    tick();
    chk("fl_no_c", {63'd0, o_valid}, 64'd0);

    // Reset while FULL, with input offered in the same cycle.
    i_ready = 0; i_valid = 1; i_data = 64'h3;
    tick();
    i_data = 64'h4;
    tick();
    i_arst = 1; i_data = 64'h5;
    tick();
    i_arst = 0; i_valid = 0;
    chk("rst2_valid", {63'd0, o_valid}, 64'd0);
    chk("rst2_ready", {63'd0, o_ready}, 64'd1);
    chk("rst2_data", o_data, 64'd0);
    chk("rst2_occ", {62'd0, o_occupancy}, 64'd0);
`ifdef PIPE_STAGE_PERF_EN
    chk("rst2_stall", DW'(o_stall_cycles), 64'd0);
    chk("rst2_drops", DW'(o_flush_drops), 64'd0);
`endif

    // Random traffic alternates between mostly-ready and mostly-stalled phases.
    for (int c = 0; c < 10000; c++) begin
      bit busy;
      busy    = ((c / 200) % 2) == 1;
      i_arst  = ($urandom_range(0, 1999) == 0);
      i_flush = ($urandom_range(0, 39) == 0);
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      i_data  = {$urandom, $urandom};
      tick();
    end
    i_arst = 0; i_flush = 0; i_valid = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
